sha_message_scheduler: RTL

Sequential SHA-256 message schedule source. Accepts one 512-bit message block over a valid/ready handshake and streams W_0..W_{ROUNDS-1} one word per cycle to the compression core, also with valid/ready. It is the iterative counterpart of the pipelined expander: a single 16-word window is recomputed in place instead of unrolled in stages.

---
 rtl/sha_pkg.sv | 28 ++
 rtl/sha_message_sigma_next.sv | 12 +
 rtl/sha_message_scheduler.sv | 84 ++++++++
 3 files changed

// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - SHA-256 schedule types, round constants and sigma functions.
package sha_pkg;

  typedef logic [31:0]       word_t;
  typedef logic [15:0][31:0] window_t;

  localparam int T_W = 6;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha_message_sigma_next.sv
// rtl/sha_message_sigma_next.sv - next schedule word W_{t+16} from the window W_t..W_{t+15}.
module sha_message_sigma_next
  import sha_pkg::*;
(
  input  window_t win_i,
  output word_t   next_o
);

  // win_i[15]=W_t, win_i[14]=W_{t+1}, win_i[6]=W_{t+9}, win_i[1]=W_{t+14}
  assign next_o = sigma1(win_i[1]) + win_i[6] + sigma0(win_i[14]) + win_i[15];

endmodule

// File: rtl/sha_message_scheduler.sv
// rtl/sha_message_scheduler.sv - iterative SHA-256 message schedule source; SHA_SCHED_K_ADD_EN adds K_t to w_o.
module sha_message_scheduler
  import sha_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           blk_valid_i,
  output logic           blk_ready_o,
  input  window_t        block_i,
  output logic           w_valid_o,
  input  logic           w_ready_i,
  output word_t          w_o,
  output logic [T_W-1:0] t_o,
  output logic           w_last_o
);

  localparam logic [0:0]     ST_IDLE = 1'b0;
  localparam logic [0:0]     ST_RUN  = 1'b1;
  localparam logic [T_W-1:0] T_LAST  = T_W'(ROUNDS - 1);

  logic [0:0]     state_q, state_d;
  window_t        win_q, win_d;
  logic [T_W-1:0] t_q, t_d;
  word_t          next_w;
  word_t          word;
  logic           run, last, w_acc, blk_acc;

  sha_message_sigma_next u_next (
    .win_i  (win_q),
    .next_o (next_w)
  );

  assign run     = (state_q == ST_RUN);
  assign last    = (t_q == T_LAST);
  assign w_acc   = run & w_ready_i;
  assign blk_ready_o = !run | (last & w_ready_i);
  assign blk_acc = blk_valid_i & blk_ready_o;

`ifdef SHA_SCHED_K_ADD_EN
  assign word = win_q[15] + K[t_q];
`else
  assign word = win_q[15];
`endif

  // Gated so the K-add build also presents zero while idle.
  assign w_o       = run ? word : '0;
  assign w_valid_o = run;
  assign t_o       = t_q;
  assign w_last_o  = run & last;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    t_d     = t_q;
    if (blk_acc) begin
      win_d   = block_i;
      t_d     = '0;
      state_d = ST_RUN;
    end else if (w_acc) begin
      win_d = {win_q[14:0], next_w};
      if (last) begin
        t_d     = '0;
        state_d = ST_IDLE;
      end else begin
        t_d = t_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      t_q     <= t_d;
    end
  end

endmodule
